// File: rtl/mmio_uart_ctrl.sv
// UART MMIO window controller: TX FIFO toward the host, one-entry RX holding register toward the CPU.
// Optional interrupt output and enables are built when MMIO_UART_IRQ_EN is defined.
module mmio_uart_ctrl #(
  parameter int unsigned TX_DEPTH  = 8,
  parameter logic [31:0] MMIO_BASE = 32'hA00003F0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_we,
  output logic        cpu_hit,
  output logic [31:0] cpu_rdata,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_consumed
`ifdef MMIO_UART_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int unsigned AW = $clog2(TX_DEPTH);

  typedef enum logic {RX_IDLE, RX_FULL} rx_state_t;

  logic [7:0]  mem [TX_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        tx_ovf, tx_empty, tx_full;
  logic        tx_push, tx_pop, tx_accept;
  logic        status_wr, rxpop_wr;
  rx_state_t   rx_state;
  logic        rx_full;
  logic [7:0]  rx_hold;
  logic [31:0] status_word;
  logic        unused_ok;

  assign cpu_hit   = (cpu_addr & 32'hFFFFFFF0) == MMIO_BASE;
  assign tx_push   = cpu_we & cpu_hit & (cpu_addr[3:2] == 2'd0);
  assign status_wr = cpu_we & cpu_hit & (cpu_addr[3:2] == 2'd2);
  assign rxpop_wr  = cpu_we & cpu_hit & (cpu_addr[3:2] == 2'd3);

  assign tx_empty  = wr_ptr == rd_ptr;
  assign tx_full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign tx_valid  = !tx_empty;
  assign tx_data   = mem[rd_ptr[AW-1:0]];
  assign tx_pop    = tx_valid & tx_ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign tx_accept = tx_push & (!tx_full | tx_pop);

  assign rx_full   = rx_state == RX_FULL;
  assign unused_ok = ^{cpu_addr[1:0], cpu_wdata[31:8]};

`ifdef MMIO_UART_IRQ_EN
  logic ie_rx, ie_tx;
`endif

  always_comb begin
    status_word = {27'h0, tx_ovf, tx_full, tx_empty, 1'b0, rx_full};
`ifdef MMIO_UART_IRQ_EN
    status_word[6:5] = {ie_tx, ie_rx};
`endif
  end

  always_comb begin
    cpu_rdata = '0;
    if (cpu_hit) begin
      case (cpu_addr[3:2])
        2'd1:    cpu_rdata = {24'h0, rx_hold};
        2'd2:    cpu_rdata = status_word;
        default: cpu_rdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      tx_ovf <= 1'b0;
      for (int unsigned i = 0; i < TX_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (tx_accept) begin
        mem[wr_ptr[AW-1:0]] <= cpu_wdata[7:0];
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (tx_pop) rd_ptr <= rd_ptr + 1'b1;
      if (status_wr) tx_ovf <= 1'b0;
      else if (tx_push && !tx_accept) tx_ovf <= 1'b1;
    end
  end

  // RXPOP takes priority over a waiting host byte; capture resumes from IDLE next cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state    <= RX_IDLE;
      rx_hold     <= '0;
      rx_consumed <= 1'b0;
    end else begin
      rx_consumed <= 1'b0;
      case (rx_state)
        RX_IDLE: if (rx_valid) begin
          rx_hold     <= rx_data;
          rx_consumed <= 1'b1;
          rx_state    <= RX_FULL;
        end
        RX_FULL: if (rxpop_wr) rx_state <= RX_IDLE;
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

`ifdef MMIO_UART_IRQ_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ie_rx <= 1'b0;
      ie_tx <= 1'b0;
      irq   <= 1'b0;
    end else begin
      if (status_wr) begin
        ie_rx <= cpu_wdata[5];
        ie_tx <= cpu_wdata[6];
      end
      irq <= (rx_full & ie_rx) | (tx_empty & ie_tx);
    end
  end
`endif

endmodule

// File: tb/tb_mmio_uart_ctrl.sv
// Directed self-checking bench for mmio_uart_ctrl (TX FIFO, RX hold, reset, optional irq).
module tb_mmio_uart_ctrl;

  localparam logic [31:0] BASE = 32'hA00003F0;

  logic        clk, rst;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_we, cpu_hit;
  logic        tx_valid, tx_ready, rx_valid, rx_consumed;
  logic [7:0]  tx_data, rx_data;
`ifdef MMIO_UART_IRQ_EN
  logic        irq;
`endif

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [31:0] rv;

  mmio_uart_ctrl #(.TX_DEPTH(8), .MMIO_BASE(BASE)) dut (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
    .cpu_hit(cpu_hit), .cpu_rdata(cpu_rdata),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_consumed(rx_consumed)
`ifdef MMIO_UART_IRQ_EN
    , .irq(irq)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    cpu_addr  = addr;
    cpu_wdata = data;
    cpu_we    = 1'b1;
    tick();
    cpu_we    = 1'b0;
    cpu_addr  = '0;
  endtask

  task automatic rd(input logic [31:0] addr, output logic [31:0] data);
    cpu_addr = addr;
    #1;
    data = cpu_rdata;
    cpu_addr = '0;
  endtask

  task automatic pop_one();
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_we = 1'b0;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
    #12;
    check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    check("rst_tx_data", {24'h0, tx_data}, 32'h0);
    check("rst_rx_consumed", {31'h0, rx_consumed}, 32'h0);
    cpu_addr = BASE + 32'h8; #1;
    check("hit_in", {31'h0, cpu_hit}, 32'h1);
    check("rst_status", cpu_rdata, 32'h4);
    cpu_addr = BASE + 32'h10; #1;
    check("hit_out", {31'h0, cpu_hit}, 32'h0);
    check("rdata_miss", cpu_rdata, 32'h0);
    @(negedge clk); rst = 1'b1;
    tick();

    // single byte, latency 1, then drain
    store(BASE, 32'h41);
    check("t1_valid", {31'h0, tx_valid}, 32'h1);
    check("t1_data", {24'h0, tx_data}, 32'h41);
    rd(BASE + 32'h8, rv); check("t1_status", rv, 32'h0);
    rd(BASE, rv); check("txdata_read0", rv, 32'h0);
    pop_one();
    check("t1_valid_after", {31'h0, tx_valid}, 32'h0);
    rd(BASE + 32'h8, rv); check("t1_status_empty", rv, 32'h4);

    // overflow with 9 stores into 8 entries
    for (int i = 1; i <= 9; i++) store(BASE, i);
    rd(BASE + 32'h8, rv); check("t2_status_ovf", rv, 32'h18);
    tick(); tick();
    check("t2_hold_stable", {24'h0, tx_data}, 32'h01);
    for (int i = 1; i <= 8; i++) begin
      check("t2_drain_valid", {31'h0, tx_valid}, 32'h1);
      check("t2_drain_data", {24'h0, tx_data}, i);
      pop_one();
    end
    check("t2_empty", {31'h0, tx_valid}, 32'h0);
    rd(BASE + 32'h8, rv); check("t2_ovf_sticky", rv, 32'h14);
    store(BASE + 32'h8, 32'h0);
    rd(BASE + 32'h8, rv); check("t2_ovf_clr", rv, 32'h4);

    // push+pop while full: no overflow, byte lands last
    for (int i = 0; i < 8; i++) store(BASE, 32'hA0 + i);
    rd(BASE + 32'h8, rv); check("t3_full", rv, 32'h8);
    cpu_addr = BASE; cpu_wdata = 32'h55; cpu_we = 1'b1; tx_ready = 1'b1;
    tick();
    cpu_we = 1'b0; tx_ready = 1'b0; cpu_addr = '0;
    rd(BASE + 32'h8, rv); check("t3_no_ovf", rv, 32'h8);
    for (int i = 1; i < 8; i++) begin
      check("t3_drain", {24'h0, tx_data}, 32'hA0 + i);
      pop_one();
    end
    check("t3_last", {24'h0, tx_data}, 32'h55);
    pop_one();
    check("t3_empty", {31'h0, tx_valid}, 32'h0);

    // push with ready high while empty: push only
    tx_ready = 1'b1;
    store(BASE, 32'h66);
    tx_ready = 1'b0;
    check("empty_pushpop_valid", {31'h0, tx_valid}, 32'h1);
    check("empty_pushpop_data", {24'h0, tx_data}, 32'h66);
    pop_one();
    store(BASE + 32'h10, 32'h77);
    check("outside_write", {31'h0, tx_valid}, 32'h0);

    // RX capture, hold, pop
    rx_data = 8'h7A; rx_valid = 1'b1;
    tick();
    check("t4_ack", {31'h0, rx_consumed}, 32'h1);
    rx_data = 8'h33;
    rd(BASE + 32'h8, rv); check("t4_status", rv, 32'h5);
    rd(BASE + 32'h4, rv); check("t4_rx1", rv, 32'h7A);
    rd(BASE + 32'h4, rv); check("t4_rx2", rv, 32'h7A);
    tick();
    check("t4_no_ack", {31'h0, rx_consumed}, 32'h0);
    store(BASE + 32'h4, 32'hFF);
    check("t4_no_ack2", {31'h0, rx_consumed}, 32'h0);
    rd(BASE + 32'h4, rv); check("t4_rxdata_ro", rv, 32'h7A);
    store(BASE + 32'hC, 32'h0);
    check("t4_pop_no_ack", {31'h0, rx_consumed}, 32'h0);
    rd(BASE + 32'h8, rv); check("t4_popped", rv, 32'h4);
    tick();
    rx_valid = 1'b0;
    check("t4_ack2", {31'h0, rx_consumed}, 32'h1);
    rd(BASE + 32'h4, rv); check("t4_rx33", rv, 32'h33);
    tick();
    check("t4_ack_pulse", {31'h0, rx_consumed}, 32'h0);
    rd(BASE + 32'h8, rv); check("t4_full_again", rv, 32'h5);

`ifndef MMIO_UART_IRQ_EN
    store(BASE + 32'h8, 32'h60);
    rd(BASE + 32'h8, rv); check("no_irq_bits", rv, 32'h5);
`endif

    // asynchronous reset mid-drain
    for (int i = 0; i < 4; i++) store(BASE, 32'hB0 + i);
    pop_one();
    rd(BASE + 32'h8, rv); check("t5_pre", rv, 32'h1);
    check("t5_pre_data", {24'h0, tx_data}, 32'hB1);
    #2;
    cpu_addr = BASE + 32'h8;
    rst = 1'b0;
    #1;
    check("t5_valid", {31'h0, tx_valid}, 32'h0);
    check("t5_status", cpu_rdata, 32'h4);
    cpu_addr = BASE + 32'h4; #1;
    check("t5_rxhold", cpu_rdata, 32'h0);
    cpu_addr = '0;
    tick();
    @(negedge clk); rst = 1'b1;
    tick();

`ifdef MMIO_UART_IRQ_EN
    store(BASE + 32'h8, 32'h20);
    rd(BASE + 32'h8, rv); check("irq_status_ie", rv, 32'h24);
    check("irq_idle", {31'h0, irq}, 32'h0);
    rx_data = 8'h10; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    check("irq_capture_edge", {31'h0, irq}, 32'h0);
    tick();
    check("irq_set", {31'h0, irq}, 32'h1);
    store(BASE + 32'hC, 32'h0);
    check("irq_pop_edge", {31'h0, irq}, 32'h1);
    tick();
    check("irq_clr", {31'h0, irq}, 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
